// File: rtl/riscv_pkg.sv
// Shared datapath widths and control-bundle layout for the ID/EX pipeline slice.
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 8;

  // Bit positions inside the control bundle, MSB first.
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALU_OP_HI  = 1;
  localparam int CTRL_ALU_OP_LO  = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the decode instruction and a load in EX.
module load_use_detect (
  input  logic       in_valid,
  input  logic       out_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  always_comb begin
    hazard = in_valid & out_valid & ex_mem_read & (ex_rd != 5'd0) &
             ((ex_rd == rs1) | (ex_rd == rs2));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and back-pressure.
// Define ID_EX_WB_BYPASS_EN to forward same-cycle write-back data into captured operands.
module id_ex_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int CTRL_W = riscv_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   rdata1,
  input  logic [XLEN-1:0]   rdata2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       bubble_cnt
);

  import riscv_pkg::*;

  logic            hazard;
  logic            accept;
  logic            stall_bubble;
  logic [XLEN-1:0] op1_next;
  logic [XLEN-1:0] op2_next;

  load_use_detect u_load_use_detect (
    .in_valid    (in_valid),
    .out_valid   (out_valid),
    .ex_mem_read (out_ctrl[CTRL_MEM_READ]),
    .ex_rd       (out_rd),
    .rs1         (in_rs1),
    .rs2         (in_rs2),
    .hazard      (hazard)
  );

  always_comb begin
    in_ready     = !reset & !flush & !hazard & (!out_valid | out_ready);
    accept       = in_valid & in_ready;
    stall_bubble = hazard & (out_ready | !out_valid) & !flush;
  end

  // Register x0 always reads as zero, even if write-back targets it.
`ifdef ID_EX_WB_BYPASS_EN
  always_comb begin
    op1_next = rdata1;
    op2_next = rdata2;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == in_rs1)) op1_next = wb_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == in_rs2)) op2_next = wb_data;
    if (in_rs1 == 5'd0) op1_next = '0;
    if (in_rs2 == 5'd0) op2_next = '0;
  end
`else
  logic unused_wb;
  assign unused_wb = &{1'b0, wb_we, wb_rd, wb_data};

  always_comb begin
    op1_next = (in_rs1 == 5'd0) ? '0 : rdata1;
    op2_next = (in_rs2 == 5'd0) ? '0 : rdata2;
  end
`endif

  // Bubbles and drains only clear out_valid; data fields keep their old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_imm   <= '0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_rd    <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_imm   <= in_imm;
      out_op1   <= op1_next;
      out_op2   <= op2_next;
      out_rs1   <= in_rs1;
      out_rs2   <= in_rs2;
      out_rd    <= in_rd;
      out_ctrl  <= in_ctrl;
    end else if (out_valid && !out_ready) begin
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (stall_bubble && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule
